// File: rtl/meta_align_fifo_pkg.sv
// Shared types and helpers for the metadata/payload aligner.
// FSM encoding, length-field width and the tkeep popcount used by the length check.
package meta_align_pkg;
    localparam int LEN_W    = 16;
    localparam int KEEP_MAX = 128;

    typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_e;

    function automatic logic [LEN_W-1:0] popcount(input logic [KEEP_MAX-1:0] v);
        logic [LEN_W-1:0] c;
        c = '0;
        for (int i = 0; i < KEEP_MAX; i++) c = c + LEN_W'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/meta_align_fifo_if.sv
// Bus bundle for meta_align_fifo: payload in, metadata in, aligned payload out.
// slave = the aligner's view, master = the surrounding environment's view.
interface meta_align_fifo_if #(
    parameter int DATA_WIDTH = 64,
    parameter int META_WIDTH = 128,
    parameter int META_DEPTH = 4
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int LW = $clog2(META_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic [KW-1:0]         s_axis_tkeep;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic                  s_axis_tlast;
    logic [META_WIDTH-1:0] s_meta_data;
    logic                  s_meta_valid;
    logic                  s_meta_ready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [KW-1:0]         m_axis_tkeep;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic [META_WIDTH-1:0] m_axis_tmeta;
    logic                  m_axis_tfirst;
    logic [LW-1:0]         meta_level;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        input  s_meta_data, s_meta_valid, m_axis_tready,
        output s_axis_tready, s_meta_ready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        output m_axis_tmeta, m_axis_tfirst, meta_level
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        output s_meta_data, s_meta_valid, m_axis_tready,
        input  s_axis_tready, s_meta_ready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tmeta, m_axis_tfirst, meta_level
    );
endinterface

// File: rtl/meta_align_fifo_skid.sv
// axis_skid_reg: 2-entry registered valid/ready stage, full throughput, stable output while stalled.
// Ready toward the source is a pure register (no combinational path from out ready).
module axis_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);
    logic             out_vld_q, skid_vld_q;
    logic [WIDTH-1:0] out_dat_q, skid_dat_q;
    logic             out_free;

    assign out_free = ready_i | ~out_vld_q;
    assign ready_o  = ~skid_vld_q;
    assign valid_o  = out_vld_q;
    assign data_o   = out_dat_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else if (out_free) begin
            out_vld_q  <= skid_vld_q | valid_i;
            skid_vld_q <= 1'b0;
        end else if (valid_i && !skid_vld_q) begin
            skid_vld_q <= 1'b1;
        end
    end

    // Data regs carry no reset; validity is tracked by the flags above.
    always_ff @(posedge clk) begin
        if (out_free) begin
            if (skid_vld_q)   out_dat_q <= skid_dat_q;
            else if (valid_i) out_dat_q <= data_i;
        end else if (valid_i && !skid_vld_q) begin
            skid_dat_q <= data_i;
        end
    end
endmodule

// File: rtl/meta_align_fifo.sv
// Queues metadata ahead of payload packets and attaches the head entry to every beat.
// Optional byte-length check enabled by defining META_ALIGN_LEN_CHECK_EN.
module meta_align_fifo
    import meta_align_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int META_WIDTH = 128,
    parameter int META_DEPTH = 4,
    parameter int LEN_LSB    = 0
) (
    input  logic clk,
    input  logic rstn,
    meta_align_fifo_if.slave bus
`ifdef META_ALIGN_LEN_CHECK_EN
    ,
    output logic             len_err,
    output logic [LEN_W-1:0] len_err_cnt
`endif
);
    localparam int AW = $clog2(META_DEPTH);
    localparam int KW = DATA_WIDTH / 8;
    localparam int PW = DATA_WIDTH + KW + META_WIDTH + 2;

    logic [META_WIDTH-1:0] mem_q [META_DEPTH];
    logic [AW:0]           wr_ptr_q, rd_ptr_q, level;
    logic                  rdy_en_q, full, empty, push, beat, pop;
    logic [META_WIDTH-1:0] head;
    state_e                state_q, state_d;
    logic                  first_pend_q, first_pend_d;
    logic                  skid_in_vld, skid_in_rdy, skid_out_vld, out_first;
    logic [PW-1:0]         skid_in, skid_out;

    assign level  = wr_ptr_q - rd_ptr_q;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head   = mem_q[rd_ptr_q[AW-1:0]];

    // rdy_en_q holds meta ready low for the first cycle out of reset.
    assign bus.s_meta_ready  = rdy_en_q & ~full;
    assign push              = bus.s_meta_valid & bus.s_meta_ready;
    assign bus.s_axis_tready = (state_q == PKT) & skid_in_rdy;
    assign beat              = bus.s_axis_tvalid & bus.s_axis_tready;
    assign pop               = beat & bus.s_axis_tlast;
    assign bus.meta_level    = level;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.s_meta_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rdy_en_q     <= 1'b0;
            state_q      <= IDLE;
            first_pend_q <= 1'b0;
        end else begin
            rdy_en_q     <= 1'b1;
            state_q      <= state_d;
            first_pend_q <= first_pend_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        first_pend_d = first_pend_q;
        case (state_q)
            IDLE: if (!empty) begin
                state_d      = PKT;
                first_pend_d = 1'b1;
            end
            PKT: if (beat) begin
                first_pend_d = 1'b0;
                // A same-cycle push lands at the head in time for the next beat.
                if (bus.s_axis_tlast) begin
                    if (level > (AW+1)'(1) || push) first_pend_d = 1'b1;
                    else                            state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign skid_in_vld = (state_q == PKT) & bus.s_axis_tvalid;
    assign skid_in     = {head, bus.s_axis_tdata, bus.s_axis_tkeep, bus.s_axis_tlast, first_pend_q};

    axis_skid_reg #(.WIDTH(PW)) u_skid (
        .clk     (clk),
        .rstn    (rstn),
        .valid_i (skid_in_vld),
        .ready_o (skid_in_rdy),
        .data_i  (skid_in),
        .valid_o (skid_out_vld),
        .ready_i (bus.m_axis_tready),
        .data_o  (skid_out)
    );

    assign {bus.m_axis_tmeta, bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast, out_first} = skid_out;
    assign bus.m_axis_tvalid = skid_out_vld;
    assign bus.m_axis_tfirst = skid_out_vld & out_first;

`ifdef META_ALIGN_LEN_CHECK_EN
    logic [LEN_W-1:0]    bytes_q, bytes_sum, err_cnt_q;
    logic [LEN_W:0]      bytes_raw;
    logic [KEEP_MAX-1:0] keep_ext;
    logic                len_err_q;

    assign keep_ext  = {{(KEEP_MAX-KW){1'b0}}, bus.s_axis_tkeep};
    assign bytes_raw = {1'b0, bytes_q} + {1'b0, popcount(keep_ext)};
    assign bytes_sum = bytes_raw[LEN_W] ? '1 : bytes_raw[LEN_W-1:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bytes_q   <= '0;
            err_cnt_q <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            if (beat) begin
                if (bus.s_axis_tlast) begin
                    bytes_q <= '0;
                    if (bytes_sum != head[LEN_LSB +: LEN_W]) begin
                        len_err_q <= 1'b1;
                        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
                    end
                end else begin
                    bytes_q <= bytes_sum;
                end
            end
        end
    end

    assign len_err     = len_err_q;
    assign len_err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_meta_align_fifo.sv
// Directed bench for meta_align_fifo: reset, single packet, FIFO full, back-to-back,
// hold-off, random output stall and (when META_ALIGN_LEN_CHECK_EN is defined) the length check.
module tb_meta_align_fifo;
    localparam int DW = 64;
    localparam int MW = 128;
    localparam int MD = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [7:0]    keep;
        logic          last;
        logic          first;
        logic [MW-1:0] meta;
        int            cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    meta_align_fifo_if #(.DATA_WIDTH(DW), .META_WIDTH(MW), .META_DEPTH(MD)) bus ();

`ifdef META_ALIGN_LEN_CHECK_EN
    logic        len_err;
    logic [15:0] len_err_cnt;
`endif

    meta_align_fifo #(.DATA_WIDTH(DW), .META_WIDTH(MW), .META_DEPTH(MD), .LEN_LSB(0)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef META_ALIGN_LEN_CHECK_EN
        ,
        .len_err     (len_err),
        .len_err_cnt (len_err_cnt)
`endif
    );

    beat_t outq[$];
    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    int    len_pulses = 0;
    logic  rs_done = 1'b0;
    logic  stall_prev = 1'b0;
    logic [202:0] held, now_out;

    // Edge monitor: collects output handshakes and checks stability while stalled.
    initial forever begin
        @(posedge clk);
        now_out = {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tkeep,
                   bus.m_axis_tlast, bus.m_axis_tfirst, bus.m_axis_tmeta};
        if (rstn && stall_prev) begin
            checks++;
            if (now_out !== held) begin
                errors++;
                $display("FAIL stall_stable: got %h want %h", now_out, held);
            end
        end
        if (rstn && bus.m_axis_tvalid && bus.m_axis_tready)
            outq.push_back('{bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast,
                             bus.m_axis_tfirst, bus.m_axis_tmeta, cyc});
`ifdef META_ALIGN_LEN_CHECK_EN
        if (rstn && len_err === 1'b1) len_pulses++;
`endif
        stall_prev = rstn && bus.m_axis_tvalid && !bus.m_axis_tready;
        held = now_out;
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic push_meta(input logic [MW-1:0] m, output int edge_id);
        bus.s_meta_data  = m;
        bus.s_meta_valid = 1'b1;
        edge_id = -1;
        for (int n = 0; n < 200; n++) begin
            logic acc;
            int   e;
            acc = bus.s_meta_ready;
            e   = cyc;
            @(posedge clk); #1;
            if (acc) begin edge_id = e; break; end
        end
        bus.s_meta_valid = 1'b0;
        if (edge_id < 0) begin
            checks++; errors++;
            $display("FAIL push_meta_timeout: got no handshake want handshake");
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [7:0] k, input logic l,
                             output int edge_id);
        bus.s_axis_tdata  = d;
        bus.s_axis_tkeep  = k;
        bus.s_axis_tlast  = l;
        bus.s_axis_tvalid = 1'b1;
        edge_id = -1;
        for (int n = 0; n < 200; n++) begin
            logic acc;
            int   e;
            acc = bus.s_axis_tready;
            e   = cyc;
            @(posedge clk); #1;
            if (acc) begin edge_id = e; break; end
        end
        bus.s_axis_tvalid = 1'b0;
        if (edge_id < 0) begin
            checks++; errors++;
            $display("FAIL send_beat_timeout: got no handshake want handshake");
        end
    endtask

    task automatic wait_outs(input int n);
        for (int k = 0; k < 300 && outq.size() < n; k++) begin @(posedge clk); #1; end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.s_axis_tvalid = 1'b0; bus.s_meta_valid = 1'b0; bus.m_axis_tready = 1'b0;
        bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0; bus.s_axis_tlast = 1'b0;
        bus.s_meta_data = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.s_meta_ready !== 1'b0) begin errors++; $display("FAIL reset_meta_ready: got %b want 0", bus.s_meta_ready); end
        checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_axis_ready: got %b want 0", bus.s_axis_tready); end
        checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", bus.m_axis_tvalid); end
        checks++; if (bus.m_axis_tfirst !== 1'b0) begin errors++; $display("FAIL reset_m_first: got %b want 0", bus.m_axis_tfirst); end
        checks++; if (bus.meta_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.meta_level); end
        rstn = 1'b1;
        checks++; if (bus.s_meta_ready !== 1'b0) begin errors++; $display("FAIL reset_release_same_cycle: got %b want 0", bus.s_meta_ready); end
        @(posedge clk); #1;
        checks++; if (bus.s_meta_ready !== 1'b1) begin errors++; $display("FAIL reset_release_next_cycle: got %b want 1", bus.s_meta_ready); end
        checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_idle_tready: got %b want 0", bus.s_axis_tready); end
    endtask

    task automatic test_single_pkt();
        logic [MW-1:0] ma;
        logic [DW-1:0] ed [3];
        int pe, e0, e1, e2;
        ma = 128'hAAAA_0000_1111_2222_3333_4444_5555_0014;
        ed[0] = 64'h1111_0000_0000_0001; ed[1] = 64'h2222_0000_0000_0002; ed[2] = 64'h3333_0000_0000_0003;
        outq.delete();
        bus.m_axis_tready = 1'b1;
        push_meta(ma, pe);
        send_beat(ed[0], 8'hFF, 1'b0, e0);
        send_beat(ed[1], 8'hFF, 1'b0, e1);
        send_beat(ed[2], 8'hFF, 1'b1, e2);
        wait_outs(3);
        checks++; if (outq.size() != 3) begin errors++; $display("FAIL single_count: got %0d want 3", outq.size()); end
        checks++; if (e2 != e0 + 2) begin errors++; $display("FAIL single_in_rate: got %0d want %0d", e2, e0 + 2); end
        for (int i = 0; i < outq.size() && i < 3; i++) begin
            checks++; if (outq[i].data !== ed[i]) begin errors++; $display("FAIL single_data%0d: got %h want %h", i, outq[i].data, ed[i]); end
            checks++; if (outq[i].meta !== ma) begin errors++; $display("FAIL single_meta%0d: got %h want %h", i, outq[i].meta, ma); end
            checks++; if (outq[i].first !== (i == 0)) begin errors++; $display("FAIL single_first%0d: got %b want %b", i, outq[i].first, (i == 0)); end
            checks++; if (outq[i].last !== (i == 2)) begin errors++; $display("FAIL single_last%0d: got %b want %b", i, outq[i].last, (i == 2)); end
        end
        if (outq.size() == 3) begin
            checks++; if (outq[0].cyc != e0 + 1) begin errors++; $display("FAIL single_latency: got %0d want %0d", outq[0].cyc, e0 + 1); end
            checks++; if (outq[2].cyc != outq[0].cyc + 2) begin errors++; $display("FAIL single_out_rate: got %0d want %0d", outq[2].cyc, outq[0].cyc + 2); end
        end
        checks++; if (bus.meta_level !== 3'd0) begin errors++; $display("FAIL single_level: got %0d want 0", bus.meta_level); end
    endtask

    task automatic test_fifo_full();
        logic [MW-1:0] mb [5];
        logic          ef [6];
        int pe, le, x;
        for (int i = 0; i < 5; i++) mb[i] = {96'hB0B0_0000_0000_0000_0000_0000, 32'(i)};
        outq.delete();
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) push_meta(mb[i], x);
        checks++; if (bus.meta_level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d want 4", bus.meta_level); end
        checks++; if (bus.s_meta_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", bus.s_meta_ready); end
        fork
            push_meta(mb[4], pe);
            begin
                repeat (3) begin @(posedge clk); #1; end
                send_beat(64'hF0, 8'hFF, 1'b0, x);
                send_beat(64'hF1, 8'hFF, 1'b1, le);
            end
        join
        checks++; if (pe != le + 1) begin errors++; $display("FAIL full_push_after_pop: got %0d want %0d", pe, le + 1); end
        checks++; if (bus.meta_level !== 3'd4) begin errors++; $display("FAIL full_level_after: got %0d want 4", bus.meta_level); end
        for (int i = 1; i < 5; i++) send_beat(64'hF0 + 64'(i + 1), 8'hFF, 1'b1, x);
        wait_outs(6);
        ef[0] = 1'b1; ef[1] = 1'b0; ef[2] = 1'b1; ef[3] = 1'b1; ef[4] = 1'b1; ef[5] = 1'b1;
        checks++; if (outq.size() != 6) begin errors++; $display("FAIL full_count: got %0d want 6", outq.size()); end
        for (int i = 0; i < outq.size() && i < 6; i++) begin
            checks++; if (outq[i].meta !== mb[i == 0 ? 0 : i - 1]) begin errors++; $display("FAIL full_meta%0d: got %h want %h", i, outq[i].meta, mb[i == 0 ? 0 : i - 1]); end
            checks++; if (outq[i].first !== ef[i]) begin errors++; $display("FAIL full_first%0d: got %b want %b", i, outq[i].first, ef[i]); end
        end
        checks++; if (bus.meta_level !== 3'd0) begin errors++; $display("FAIL full_drain_level: got %0d want 0", bus.meta_level); end
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] ma, mb;
        int x, ea, eb;
        ma = 128'hA2; mb = 128'hB2;
        outq.delete();
        bus.m_axis_tready = 1'b1;
        push_meta(ma, x);
        push_meta(mb, x);
        send_beat(64'hDA, 8'hFF, 1'b1, ea);
        send_beat(64'hDB, 8'h0F, 1'b1, eb);
        wait_outs(2);
        checks++; if (eb != ea + 1) begin errors++; $display("FAIL b2b_in_bubble: got %0d want %0d", eb, ea + 1); end
        checks++; if (outq.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", outq.size()); end
        if (outq.size() == 2) begin
            checks++; if (outq[1].cyc != outq[0].cyc + 1) begin errors++; $display("FAIL b2b_out_bubble: got %0d want %0d", outq[1].cyc, outq[0].cyc + 1); end
            checks++; if (outq[0].meta !== ma || outq[1].meta !== mb) begin errors++; $display("FAIL b2b_meta: got %h/%h want %h/%h", outq[0].meta, outq[1].meta, ma, mb); end
            checks++; if (!(outq[0].first === 1'b1 && outq[1].first === 1'b1)) begin errors++; $display("FAIL b2b_first: got %b%b want 11", outq[0].first, outq[1].first); end
            checks++; if (outq[1].keep !== 8'h0F || outq[1].data !== 64'hDB) begin errors++; $display("FAIL b2b_beat1: got %h/%h want 0f/db", outq[1].keep, outq[1].data); end
        end
    endtask

    task automatic test_holdoff();
        logic [MW-1:0] mc;
        int pe, ae;
        mc = 128'hC0C0_C0C0;
        outq.delete();
        bus.m_axis_tready = 1'b1;
        bus.s_axis_tdata = 64'hDC; bus.s_axis_tkeep = 8'hFF; bus.s_axis_tlast = 1'b1;
        bus.s_axis_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL holdoff_ready%0d: got %b want 0", i, bus.s_axis_tready); end
            @(posedge clk); #1;
        end
        fork
            push_meta(mc, pe);
            send_beat(64'hDC, 8'hFF, 1'b1, ae);
        join
        wait_outs(1);
        checks++; if (ae <= pe) begin errors++; $display("FAIL holdoff_accept: got edge %0d want > %0d", ae, pe); end
        checks++; if (outq.size() != 1) begin errors++; $display("FAIL holdoff_count: got %0d want 1", outq.size()); end
        if (outq.size() == 1) begin
            checks++; if (outq[0].meta !== mc || outq[0].first !== 1'b1) begin errors++; $display("FAIL holdoff_out: got %h/%b want %h/1", outq[0].meta, outq[0].first, mc); end
        end
    endtask

    task automatic test_random_stall();
        logic [MW-1:0] m [3];
        logic [7:0]    ek [6];
        logic          el [6], ef [6];
        int            pk [6];
        int x;
        m[0] = 128'h51; m[1] = 128'h52; m[2] = 128'h53;
        ek[0] = 8'hFF; ek[1] = 8'hFF; ek[2] = 8'h0F; ek[3] = 8'h01; ek[4] = 8'hFF; ek[5] = 8'h3F;
        el[0] = 0; el[1] = 0; el[2] = 1; el[3] = 1; el[4] = 0; el[5] = 1;
        ef[0] = 1; ef[1] = 0; ef[2] = 0; ef[3] = 1; ef[4] = 1; ef[5] = 0;
        pk[0] = 0; pk[1] = 0; pk[2] = 0; pk[3] = 1; pk[4] = 2; pk[5] = 2;
        outq.delete();
        rs_done = 1'b0;
        fork
            begin
                while (!rs_done) begin
                    bus.m_axis_tready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                bus.m_axis_tready = 1'b1;
            end
            begin
                for (int i = 0; i < 3; i++) push_meta(m[i], x);
                for (int i = 0; i < 6; i++) send_beat(64'hA000 + 64'(i), ek[i], el[i], x);
                wait_outs(6);
                rs_done = 1'b1;
            end
        join
        checks++; if (outq.size() != 6) begin errors++; $display("FAIL stall_count: got %0d want 6", outq.size()); end
        for (int i = 0; i < outq.size() && i < 6; i++) begin
            checks++;
            if (outq[i].data !== 64'hA000 + 64'(i) || outq[i].keep !== ek[i] || outq[i].last !== el[i] ||
                outq[i].first !== ef[i] || outq[i].meta !== m[pk[i]]) begin
                errors++;
                $display("FAIL stall_beat%0d: got %h/%h/%b/%b/%h want %h/%h/%b/%b/%h", i,
                         outq[i].data, outq[i].keep, outq[i].last, outq[i].first, outq[i].meta,
                         64'hA000 + 64'(i), ek[i], el[i], ef[i], m[pk[i]]);
            end
        end
    endtask

`ifdef META_ALIGN_LEN_CHECK_EN
    task automatic test_len_check();
        int x;
        do_reset();
        rstn = 1'b1;
        @(posedge clk); #1;
        checks++; if (len_err_cnt !== 16'd0) begin errors++; $display("FAIL len_reset_cnt: got %0d want 0", len_err_cnt); end
        bus.m_axis_tready = 1'b1;
        outq.delete();
        len_pulses = 0;
        push_meta({112'hBEEF, 16'd20}, x);
        send_beat(64'h1, 8'hFF, 1'b0, x);
        send_beat(64'h2, 8'hFF, 1'b0, x);
        send_beat(64'h3, 8'h0F, 1'b1, x);
        wait_outs(3);
        checks++; if (len_pulses != 0) begin errors++; $display("FAIL len_ok_pulse: got %0d want 0", len_pulses); end
        checks++; if (len_err_cnt !== 16'd0) begin errors++; $display("FAIL len_ok_cnt: got %0d want 0", len_err_cnt); end
        push_meta({112'hBEEF, 16'd20}, x);
        send_beat(64'h4, 8'hFF, 1'b0, x);
        send_beat(64'h5, 8'hFF, 1'b0, x);
        send_beat(64'h6, 8'h07, 1'b1, x);
        wait_outs(6);
        checks++; if (len_pulses != 1) begin errors++; $display("FAIL len_bad_pulse: got %0d want 1", len_pulses); end
        checks++; if (len_err_cnt !== 16'd1) begin errors++; $display("FAIL len_bad_cnt: got %0d want 1", len_err_cnt); end
        checks++; if (outq.size() != 6) begin errors++; $display("FAIL len_flow: got %0d want 6", outq.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_pkt();
        test_fifo_full();
        test_back_to_back();
        test_holdoff();
        test_random_stall();
`ifdef META_ALIGN_LEN_CHECK_EN
        test_len_check();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/meta_align_fifo.md
Name: meta_align_fifo

Overview:
- Parametrised successor to the single-entry metadata/payload aligner in the IP encapsulator path.
- Queues up to META_DEPTH UDP metadata words ahead of their payload packets.
- Attaches the head metadata as a sideband to every beat of the matching AXI-Stream packet.
- Registered output stage with full-throughput backpressure; no bubble between packets. Sits between the UDP header builder and the IP header inserter.

Parameters:
- DATA_WIDTH, 64, payload tdata width in bits (multiple of 8).
- META_WIDTH, 128, metadata word width.
- META_DEPTH, 4, metadata FIFO entries (power of two, >=2).
- LEN_LSB, 0, bit offset of the 16-bit payload byte length inside the metadata word. Used only with LEN_CHECK_EN.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  DATA_WIDTH  payload data.
- s_axis_tkeep  in  DATA_WIDTH/8  byte enables (contiguous from LSB).
- s_axis_tvalid  in  1  payload valid.
- s_axis_tready  out  1  payload ready.
- s_axis_tlast  in  1  last beat of packet.
- s_meta_data  in  META_WIDTH  metadata word, one per packet.
- s_meta_valid  in  1  metadata valid.
- s_meta_ready  out  1  metadata ready (= !fifo_full).
- m_axis_tdata  out  DATA_WIDTH  payload out.
- m_axis_tkeep  out  DATA_WIDTH/8  keep out.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last out.
- m_axis_tmeta  out  META_WIDTH  metadata of the current packet, stable on every beat.
- m_axis_tfirst  out  1  high on the first beat of each packet.
- meta_level  out  $clog2(META_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: all valid/ready outputs 0; m_axis_tfirst 0, meta_level 0, state IDLE. Data and meta registers are don't-care.
  - After reset, s_meta_ready rises the cycle after rstn deasserts.
- Meta FIFO:
  - Push on s_meta_valid & s_meta_ready; pop when the last payload beat is accepted on s_axis.
  - s_meta_ready = !full, with no look-ahead: a push while full is refused even if a pop occurs that cycle.
  - Simultaneous push+pop when neither full nor empty: occupancy unchanged.
  - Pointers wrap modulo META_DEPTH; the extra MSB distinguishes full from empty.
- FSM, 2 states:
  - IDLE: s_axis_tready=0. When the FIFO is non-empty, go to PKT and set first_pending=1.
  - PKT: s_axis_tready = skid input ready. Every accepted beat is written into the output stage with meta = FIFO head and first = first_pending; first_pending then clears.
  - On an accepted tlast beat, pop the FIFO. If occupancy after pop is >0, stay in PKT with first_pending=1 (zero-bubble back-to-back). Otherwise go to IDLE.
- Payload arriving before its meta is held off (tready=0); meta arriving early is queued.
- Output stage is a 2-entry skid register:
  - Latency: input handshake to m_axis_tvalid is 1 cycle.
  - Sustains 1 beat/clk under continuous m_axis_tready.
  - When m_axis_tvalid=1, all m_axis_* outputs stay stable until the downstream handshake completes.
- Zero-length packets are not supported: every packet has at least one beat.
- Reset mid-packet discards the FIFO contents, the output stage and any partial packet. The upstream source must also be reset.

Optional Feature:
- Macro: META_ALIGN_LEN_CHECK_EN.
- When defined:
  - Count accepted bytes per packet (popcount of tkeep, 16-bit saturating).
  - On tlast, compare against meta[LEN_LSB+:16].
  - On mismatch, pulse output len_err for 1 cycle and increment output len_err_cnt (16-bit, saturating; reset 0).
  - Data flow is unchanged.
- When undefined: no len_err or len_err_cnt ports, no counter logic.

Decomposition:
- Package meta_align_pkg:
  - FSM state encoding (IDLE, PKT).
  - Helper function for tkeep popcount.
  - Length field width constant (16).
- Sub-module axis_skid_reg:
  - Parametrised on payload width = DATA_WIDTH + DATA_WIDTH/8 + META_WIDTH + 2 (tlast, tfirst).
  - Reusable elsewhere in the encapsulator.

Test Plan:
- Push meta A, then a 3-beat packet with continuous ready → 3 output beats, all with tmeta=A, tfirst only on beat 0, tlast on beat 2, first output 1 cycle after first input handshake.
- Push 4 metas back-to-back, META_DEPTH=4 → s_meta_ready=0 after the 4th, meta_level=4. A 5th push is held until the first packet's tlast pops the FIFO.
- Two queued metas, two 1-beat packets streamed back-to-back → outputs on consecutive cycles, tmeta A then B, tfirst=1 on both, no bubble.
- Payload valid with FIFO empty → s_axis_tready stays 0. Meta arrives at cycle 10 → tready rises in cycle 11 or later.
- Random m_axis_tready at 50% → no data loss or duplication, outputs stable while stalled, 1 beat/clk when ready held high.
- With META_ALIGN_LEN_CHECK_EN: meta length 20, packet of 3 beats with tkeep FF, FF, 0F (20 bytes) → no len_err. Final tkeep 07 (19 bytes) → len_err pulse, len_err_cnt=1.
